// File: rtl/cmp_result_filter.sv
`default_nettype none
// ============================================================================
// cmp_result_filter : debounces gt/eq/lt comparator results, flags illegal
// samples and keeps saturating per-class counters.   Revision: 1.0
// ============================================================================
module cmp_result_filter #(
  parameter int DEBOUNCE = 3,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  input  logic             gt_i,
  input  logic             eq_i,
  input  logic             lt_i,
  input  logic             cnt_clr_i,
  output logic             stable_valid_o,
  output logic             stable_gt_o,
  output logic             stable_eq_o,
  output logic             stable_lt_o,
  output logic             change_o,
  output logic             err_o,
  output logic [CNT_W-1:0] gt_cnt_o,
  output logic [CNT_W-1:0] eq_cnt_o,
  output logic [CNT_W-1:0] lt_cnt_o
);

  localparam logic [3:0]       C_DEB     = 4'(DEBOUNCE);
  localparam logic [1:0]       C_GT      = 2'd0;
  localparam logic [1:0]       C_EQ      = 2'd1;
  localparam logic [1:0]       C_LT      = 2'd2;
  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

  typedef enum logic [0:0] {
    NO_RESULT = 1'b0,
    SETTLED   = 1'b1
  } state_t;

  state_t           state_q;
  logic [1:0]       cand_q, cand_d;
  logic [3:0]       run_q, run_d;
  logic [2:0]       stable_q;
  logic             change_q;
  logic             err_q;
  logic [CNT_W-1:0] gt_cnt_q, eq_cnt_q, lt_cnt_q;

  logic [2:0]       w_sample;
  logic             w_legal;
  logic [1:0]       w_cls;
  logic [2:0]       w_cand_oh;
  logic             w_publish;

  assign w_sample = {gt_i, eq_i, lt_i};

  always_comb begin
    w_legal = 1'b0;
    w_cls   = C_GT;
    if (in_valid_i) begin
      case (w_sample)
        3'b100:  begin w_legal = 1'b1; w_cls = C_GT; end
        3'b010:  begin w_legal = 1'b1; w_cls = C_EQ; end
        3'b001:  begin w_legal = 1'b1; w_cls = C_LT; end
        default: begin w_legal = 1'b0; w_cls = C_GT; end
      endcase
    end
  end

  // An illegal sample breaks the run but keeps the candidate class.
  always_comb begin
    cand_d = cand_q;
    run_d  = run_q;
    if (w_legal) begin
      if (w_cls == cand_q && run_q != 4'd0) begin
        run_d = (run_q == C_DEB) ? C_DEB : run_q + 4'd1;
      end else begin
        cand_d = w_cls;
        run_d  = 4'd1;
      end
    end else if (in_valid_i) begin
      run_d = 4'd0;
    end
  end

  always_comb begin
    case (cand_d)
      C_GT:    w_cand_oh = 3'b100;
      C_EQ:    w_cand_oh = 3'b010;
      default: w_cand_oh = 3'b001;
    endcase
  end

  assign w_publish = w_legal && (run_d == C_DEB) &&
                     ((state_q == NO_RESULT) || (stable_q != w_cand_oh));

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == C_CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= NO_RESULT;
      cand_q   <= C_GT;
      run_q    <= 4'd0;
      stable_q <= 3'b000;
      change_q <= 1'b0;
      err_q    <= 1'b0;
      gt_cnt_q <= '0;
      eq_cnt_q <= '0;
      lt_cnt_q <= '0;
    end else begin
      cand_q   <= cand_d;
      run_q    <= run_d;
      change_q <= w_publish;
      err_q    <= in_valid_i & ~w_legal;
      if (w_publish) begin
        stable_q <= w_cand_oh;
        state_q  <= SETTLED;
      end
      if (cnt_clr_i) begin
        gt_cnt_q <= '0;
        eq_cnt_q <= '0;
        lt_cnt_q <= '0;
      end else if (w_legal) begin
        case (w_cls)
          C_GT:    gt_cnt_q <= sat_inc(gt_cnt_q);
          C_EQ:    eq_cnt_q <= sat_inc(eq_cnt_q);
          default: lt_cnt_q <= sat_inc(lt_cnt_q);
        endcase
      end
    end
  end

  assign stable_valid_o = (state_q == SETTLED);
  assign stable_gt_o    = stable_q[2];
  assign stable_eq_o    = stable_q[1];
  assign stable_lt_o    = stable_q[0];
  assign change_o       = change_q;
  assign err_o          = err_q;
  assign gt_cnt_o       = gt_cnt_q;
  assign eq_cnt_o       = eq_cnt_q;
  assign lt_cnt_o       = lt_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_cmp_result_filter.sv
`default_nettype none
// ============================================================================
// tb_cmp_result_filter : table-driven scoreboard bench for cmp_result_filter.
// Revision: 1.0
// ============================================================================
module tb_cmp_result_filter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  logic gt = 1'b0, eq = 1'b0, lt = 1'b0;
  logic cnt_clr = 1'b0;

  always #5 clk = ~clk;

  // Instance A: DEBOUNCE=3, CNT_W=8
  logic       a_sv, a_sg, a_se, a_sl, a_ch, a_er;
  logic [7:0] a_gc, a_ec, a_lc;
  // Instance B: DEBOUNCE=3, CNT_W=2
  logic       b_sv, b_sg, b_se, b_sl, b_ch, b_er;
  logic [1:0] b_gc, b_ec, b_lc;
  // Instance C: DEBOUNCE=1, CNT_W=8
  logic       c_sv, c_sg, c_se, c_sl, c_ch, c_er;
  logic [7:0] c_gc, c_ec, c_lc;

  cmp_result_filter #(.DEBOUNCE(3), .CNT_W(8)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .gt_i(gt), .eq_i(eq), .lt_i(lt),
    .cnt_clr_i(cnt_clr), .stable_valid_o(a_sv), .stable_gt_o(a_sg), .stable_eq_o(a_se),
    .stable_lt_o(a_sl), .change_o(a_ch), .err_o(a_er),
    .gt_cnt_o(a_gc), .eq_cnt_o(a_ec), .lt_cnt_o(a_lc));

  cmp_result_filter #(.DEBOUNCE(3), .CNT_W(2)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .gt_i(gt), .eq_i(eq), .lt_i(lt),
    .cnt_clr_i(cnt_clr), .stable_valid_o(b_sv), .stable_gt_o(b_sg), .stable_eq_o(b_se),
    .stable_lt_o(b_sl), .change_o(b_ch), .err_o(b_er),
    .gt_cnt_o(b_gc), .eq_cnt_o(b_ec), .lt_cnt_o(b_lc));

  cmp_result_filter #(.DEBOUNCE(1), .CNT_W(8)) u_dut_c (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .gt_i(gt), .eq_i(eq), .lt_i(lt),
    .cnt_clr_i(cnt_clr), .stable_valid_o(c_sv), .stable_gt_o(c_sg), .stable_eq_o(c_se),
    .stable_lt_o(c_sl), .change_o(c_ch), .err_o(c_er),
    .gt_cnt_o(c_gc), .eq_cnt_o(c_ec), .lt_cnt_o(c_lc));

  typedef struct {
    logic       r;
    logic       v;
    logic [2:0] s;
    logic       c;
    logic       sv;
    logic [2:0] st;
    logic       ch;
    logic       er;
    logic [7:0] gc;
    logic [7:0] ec;
    logic [7:0] lc;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic vec_t mk(input logic r, input logic v, input logic [2:0] s,
                              input logic c, input logic sv, input logic [2:0] st,
                              input logic ch, input logic er, input logic [7:0] gc,
                              input logic [7:0] ec, input logic [7:0] lc);
    vec_t t;
    t.r = r; t.v = v; t.s = s; t.c = c; t.sv = sv; t.st = st;
    t.ch = ch; t.er = er; t.gc = gc; t.ec = ec; t.lc = lc;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic apply(input logic r, input logic v, input logic [2:0] s, input logic c);
    @(negedge clk);
    rst = r; in_valid = v; {gt, eq, lt} = s; cnt_clr = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t e;
    logic [2:0] c_in [4];
    logic [2:0] c_st [4];
    logic       c_chg[4];

    //            r  v  s       c  sv st      ch er gc ec lc
    tbl.push_back(mk(1, 0, 3'b000, 0, 0, 3'b000, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 3'b100, 0, 0, 3'b000, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 3'b100, 0, 0, 3'b000, 0, 0, 2, 0, 0));
    tbl.push_back(mk(0, 1, 3'b100, 0, 1, 3'b100, 1, 0, 3, 0, 0));
    tbl.push_back(mk(0, 0, 3'b000, 0, 1, 3'b100, 0, 0, 3, 0, 0));
    // run of EQ broken only by idle cycles
    tbl.push_back(mk(0, 1, 3'b010, 0, 1, 3'b100, 0, 0, 3, 1, 0));
    tbl.push_back(mk(0, 1, 3'b010, 0, 1, 3'b100, 0, 0, 3, 2, 0));
    tbl.push_back(mk(0, 0, 3'b010, 0, 1, 3'b100, 0, 0, 3, 2, 0));
    tbl.push_back(mk(0, 0, 3'b000, 0, 1, 3'b100, 0, 0, 3, 2, 0));
    tbl.push_back(mk(0, 1, 3'b010, 0, 1, 3'b010, 1, 0, 3, 3, 0));
    tbl.push_back(mk(0, 1, 3'b010, 0, 1, 3'b010, 0, 0, 3, 4, 0));
    tbl.push_back(mk(0, 1, 3'b001, 0, 1, 3'b010, 0, 0, 3, 4, 1));
    tbl.push_back(mk(0, 1, 3'b001, 0, 1, 3'b010, 0, 0, 3, 4, 2));
    tbl.push_back(mk(0, 1, 3'b001, 0, 1, 3'b001, 1, 0, 3, 4, 3));
    // illegal sample breaks the EQ run
    tbl.push_back(mk(0, 1, 3'b010, 0, 1, 3'b001, 0, 0, 3, 5, 3));
    tbl.push_back(mk(0, 1, 3'b110, 0, 1, 3'b001, 0, 1, 3, 5, 3));
    tbl.push_back(mk(0, 1, 3'b010, 0, 1, 3'b001, 0, 0, 3, 6, 3));
    tbl.push_back(mk(0, 1, 3'b010, 0, 1, 3'b001, 0, 0, 3, 7, 3));
    tbl.push_back(mk(0, 1, 3'b010, 0, 1, 3'b010, 1, 0, 3, 8, 3));
    tbl.push_back(mk(0, 1, 3'b111, 0, 1, 3'b010, 0, 1, 3, 8, 3));
    tbl.push_back(mk(0, 1, 3'b000, 0, 1, 3'b010, 0, 1, 3, 8, 3));
    tbl.push_back(mk(0, 0, 3'b000, 0, 1, 3'b010, 0, 0, 3, 8, 3));
    // counter clear, alone and concurrent with a publishing sample
    tbl.push_back(mk(0, 0, 3'b000, 1, 1, 3'b010, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 3'b001, 0, 1, 3'b010, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 3'b001, 0, 1, 3'b010, 0, 0, 0, 0, 2));
    tbl.push_back(mk(0, 1, 3'b001, 1, 1, 3'b001, 1, 0, 0, 0, 0));
    // reset wins over a valid sample and clear
    tbl.push_back(mk(1, 1, 3'b100, 1, 0, 3'b000, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 3'b000, 0, 0, 3'b000, 0, 0, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rst = tbl[i].r; in_valid = tbl[i].v; {gt, eq, lt} = tbl[i].s; cnt_clr = tbl[i].c;
      exp_q.push_back(tbl[i]);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        check("scoreboard_empty", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("v%0d_stable", i), {28'd0, a_sv, a_sg, a_se, a_sl}, {28'd0, e.sv, e.st});
        check($sformatf("v%0d_change", i), {31'd0, a_ch}, {31'd0, e.ch});
        check($sformatf("v%0d_err", i), {31'd0, a_er}, {31'd0, e.er});
        check($sformatf("v%0d_counts", i), {8'd0, a_gc, a_ec, a_lc}, {8'd0, e.gc, e.ec, e.lc});
      end
    end

    // Saturation with a 2-bit counter
    apply(1, 0, 3'b000, 0);
    check("sat_reset", {30'd0, b_gc}, 32'd0);
    for (int i = 1; i <= 5; i++) begin
      apply(0, 1, 3'b100, 0);
      check($sformatf("sat_gt_cnt_%0d", i), {30'd0, b_gc}, (i < 3) ? i : 3);
    end

    // Immediate publishing with DEBOUNCE=1
    c_in[0] = 3'b100; c_in[1] = 3'b001; c_in[2] = 3'b001; c_in[3] = 3'b010;
    c_st[0] = 3'b100; c_st[1] = 3'b001; c_st[2] = 3'b001; c_st[3] = 3'b010;
    c_chg[0] = 1'b1;  c_chg[1] = 1'b1;  c_chg[2] = 1'b0;  c_chg[3] = 1'b1;
    apply(1, 0, 3'b000, 0);
    check("db1_reset", {28'd0, c_sv, c_sg, c_se, c_sl}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      apply(0, 1, c_in[i], 0);
      check($sformatf("db1_stable_%0d", i), {28'd0, c_sv, c_sg, c_se, c_sl}, {28'd0, 1'b1, c_st[i]});
      check($sformatf("db1_change_%0d", i), {31'd0, c_ch}, {31'd0, c_chg[i]});
    end
    apply(0, 0, 3'b000, 0);
    check("db1_change_idle", {31'd0, c_ch}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
